// File: rtl/sa_autosa_cacc_pkg.sv
// Shared encodings for the CACC ping-pong register-group controller.
package sa_autosa_cacc_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_RUNNING = 2'd1;
    localparam logic [ST_W-1:0] ST_PENDING = 2'd2;

    typedef logic [ST_W-1:0] grp_st_t;

endpackage

// File: rtl/sa_autosa_cacc_run_counter.sv
// Saturating run-cycle counter with clear/enable and a watchdog compare
// that fires on the last cycle before the limit would be exceeded.
module sa_autosa_cacc_run_counter #(
    parameter int          CNT_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wd_hit_o
);

    localparam bit               WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over enable so a completing run restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wd_hit_o = WD_EN && en_i && (cnt_q == WD_LAST);

endmodule

// File: rtl/sa_autosa_cacc_grp_ctrl.sv
// Ping-pong register-group controller: tracks IDLE/RUNNING/PENDING per group,
// launches the datapath and reports status back to the single-register block.
module sa_autosa_cacc_grp_ctrl
    import sa_autosa_cacc_pkg::*;
#(
    parameter int          CNT_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rst,
    input  logic             producer,
    input  logic [1:0]       op_en_set,
    input  logic             dp_done,
    output logic             consumer,
    output logic [ST_W-1:0]  status_0,
    output logic [ST_W-1:0]  status_1,
    output logic [1:0]       op_en,
    output logic             op_load,
    output logic             op_load_grp,
    output logic             grp_wr_allow,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [1:0]       err_sticky,
    output logic             timeout
);

    grp_st_t [1:0]    st_q, st_d;
    logic             consumer_q, consumer_d;
    logic             op_load_q, op_load_d;
    logic             op_load_grp_q, op_load_grp_d;
    logic [CNT_W-1:0] perf_q, perf_d;
    logic [1:0]       err_q, err_d;
    logic             timeout_q, timeout_d;

    logic             anyRun;
    logic             doneOk;
    logic             otherGrp;
    logic [CNT_W-1:0] runCnt;
    logic             wdHit;

    assign anyRun   = (st_q[0] == ST_RUNNING) || (st_q[1] == ST_RUNNING);
    assign doneOk   = dp_done && anyRun;
    assign otherGrp = ~consumer_q;

    sa_autosa_cacc_run_counter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_run_counter (
        .clk_i    (autosa_core_clk),
        .rst_i    (autosa_core_rst),
        .clr_i    (doneOk),
        .en_i     (anyRun),
        .cnt_o    (runCnt),
        .wd_hit_o (wdHit)
    );

    // Writes are judged first; a completion then overrides the other group's
    // fate so a pending or same-cycle-accepted group starts with no gap.
    always_comb begin
        st_d          = st_q;
        consumer_d    = consumer_q;
        op_load_d     = 1'b0;
        op_load_grp_d = op_load_grp_q;
        perf_d        = perf_q;
        err_d         = err_q;
        timeout_d     = timeout_q | wdHit;

        for (int g = 0; g < 2; g++) begin
            if (op_en_set[g]) begin
                if (st_q[g] != ST_IDLE) begin
                    err_d[0] = 1'b1;
                end else if ((1'(g) == consumer_q) && !anyRun) begin
                    st_d[g]       = ST_RUNNING;
                    op_load_d     = 1'b1;
                    op_load_grp_d = 1'(g);
                end else begin
                    st_d[g] = ST_PENDING;
                end
            end
        end

        if (dp_done) begin
            if (anyRun) begin
                st_d[consumer_q] = ST_IDLE;
                consumer_d       = otherGrp;
                perf_d           = (runCnt == '1) ? runCnt : runCnt + 1'b1;
                if ((st_q[otherGrp] == ST_PENDING) ||
                    (op_en_set[otherGrp] && (st_q[otherGrp] == ST_IDLE))) begin
                    st_d[otherGrp] = ST_RUNNING;
                    op_load_d      = 1'b1;
                    op_load_grp_d  = otherGrp;
                end
            end else begin
                err_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            st_q          <= {ST_IDLE, ST_IDLE};
            consumer_q    <= 1'b0;
            op_load_q     <= 1'b0;
            op_load_grp_q <= 1'b0;
            perf_q        <= '0;
            err_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            st_q          <= st_d;
            consumer_q    <= consumer_d;
            op_load_q     <= op_load_d;
            op_load_grp_q <= op_load_grp_d;
            perf_q        <= perf_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign consumer     = consumer_q;
    assign status_0     = st_q[0];
    assign status_1     = st_q[1];
    assign op_en        = {st_q[1] != ST_IDLE, st_q[0] != ST_IDLE};
    assign op_load      = op_load_q;
    assign op_load_grp  = op_load_grp_q;
    assign grp_wr_allow = (st_q[producer] == ST_IDLE);
    assign perf_cycles  = perf_q;
    assign err_sticky   = err_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_sa_autosa_cacc_grp_ctrl.sv
// Directed scoreboard bench for the CACC ping-pong group controller,
// built with an 8-cycle watchdog so the timeout path is reachable.
module tb_sa_autosa_cacc_grp_ctrl;

    localparam int CNT_W = 20;

    typedef struct {
        logic       cons;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       ld;
        logic       ldg;
        logic       chkLdg;
        logic [1:0] err;
        logic       to;
        logic       prod;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             producer;
    logic [1:0]       opEnSet;
    logic             dpDone;
    logic             consumer;
    logic [1:0]       status0;
    logic [1:0]       status1;
    logic [1:0]       opEn;
    logic             opLoad;
    logic             opLoadGrp;
    logic             grpWrAllow;
    logic [CNT_W-1:0] perfCycles;
    logic [1:0]       errSticky;
    logic             timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    sa_autosa_cacc_grp_ctrl #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .autosa_core_clk (clk),
        .autosa_core_rst (rst),
        .producer        (producer),
        .op_en_set       (opEnSet),
        .dp_done         (dpDone),
        .consumer        (consumer),
        .status_0        (status0),
        .status_1        (status1),
        .op_en           (opEn),
        .op_load         (opLoad),
        .op_load_grp     (opLoadGrp),
        .grp_wr_allow    (grpWrAllow),
        .perf_cycles     (perfCycles),
        .err_sticky      (errSticky),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic cons, input logic [1:0] s0, input logic [1:0] s1,
                                input logic ld, input logic ldg, input logic [1:0] err,
                                input logic to);
        exp_t e;
        e.cons = cons; e.s0 = s0; e.s1 = s1; e.ld = ld; e.ldg = ldg;
        e.chkLdg = ld; e.err = err; e.to = to; e.prod = 1'b0;
        return e;
    endfunction

    function automatic exp_t mkRst();
        exp_t e;
        e = mk(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        e.chkLdg = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbq.pop_front();
        chk("consumer", 32'(consumer), 32'(e.cons));
        chk("status_0", 32'(status0), 32'(e.s0));
        chk("status_1", 32'(status1), 32'(e.s1));
        chk("op_en", 32'(opEn), 32'({e.s1 != 2'd0, e.s0 != 2'd0}));
        chk("op_load", 32'(opLoad), 32'(e.ld));
        if (e.chkLdg) chk("op_load_grp", 32'(opLoadGrp), 32'(e.ldg));
        chk("err_sticky", 32'(errSticky), 32'(e.err));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("grp_wr_allow", 32'(grpWrAllow),
            32'(e.prod ? (e.s1 == 2'd0) : (e.s0 == 2'd0)));
    endtask

    task automatic applyStimulus(input logic r, input logic prod, input logic [1:0] set,
                                 input logic done, input exp_t e);
        @(negedge clk);
        rst      = r;
        producer = prod;
        opEnSet  = set;
        dpDone   = done;
        e.prod   = prod;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; producer = 1'b0; opEnSet = 2'b00; dpDone = 1'b0;

        // Reset values, then basic launch and ping-pong hand-over.
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        chk("perf_reset", 32'(perfCycles), 32'd0);
        applyStimulus(0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 2'b00, 0));
        applyStimulus(0, 0, 2'b01, 0, mk(0, 1, 0, 1, 0, 2'b00, 0));
        applyStimulus(0, 1, 2'b00, 0, mk(0, 1, 0, 0, 0, 2'b00, 0));
        applyStimulus(0, 1, 2'b10, 0, mk(0, 1, 2, 0, 0, 2'b00, 0));
        applyStimulus(0, 0, 2'b00, 1, mk(1, 0, 1, 1, 1, 2'b00, 0));
        chk("perf_b", 32'(perfCycles), 32'd3);

        // Write to the running group is rejected; its completion returns to group 0.
        applyStimulus(0, 1, 2'b10, 0, mk(1, 0, 1, 0, 0, 2'b01, 0));
        applyStimulus(0, 0, 2'b00, 1, mk(0, 0, 0, 0, 0, 2'b01, 0));
        chk("perf_c", 32'(perfCycles), 32'd2);

        // Spurious done, then group 1 pending while idle until group 0 runs.
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        applyStimulus(0, 0, 2'b00, 1, mk(0, 0, 0, 0, 0, 2'b10, 0));
        applyStimulus(0, 1, 2'b10, 0, mk(0, 0, 2, 0, 0, 2'b10, 0));
        applyStimulus(0, 1, 2'b01, 0, mk(0, 1, 2, 1, 0, 2'b10, 0));
        applyStimulus(0, 0, 2'b00, 1, mk(1, 0, 1, 1, 1, 2'b10, 0));
        chk("perf_d", 32'(perfCycles), 32'd1);

        // 37-cycle run crossing the 8-cycle watchdog.
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        applyStimulus(0, 0, 2'b01, 0, mk(0, 1, 0, 1, 0, 2'b00, 0));
        for (int i = 1; i <= 36; i++) begin
            applyStimulus(0, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 2'b00, (i >= 8)));
        end
        applyStimulus(0, 0, 2'b00, 1, mk(1, 0, 0, 0, 0, 2'b00, 1));
        chk("perf_37", 32'(perfCycles), 32'd37);

        // Done and a write to the other idle group in the same cycle.
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        applyStimulus(0, 0, 2'b01, 0, mk(0, 1, 0, 1, 0, 2'b00, 0));
        applyStimulus(0, 0, 2'b10, 1, mk(1, 0, 1, 1, 1, 2'b00, 0));

        // Both writes together, then done plus a rejected write to the runner.
        applyStimulus(1, 0, 2'b00, 0, mkRst());
        applyStimulus(0, 0, 2'b11, 0, mk(0, 1, 2, 1, 0, 2'b00, 0));
        applyStimulus(0, 0, 2'b01, 1, mk(1, 0, 1, 1, 1, 2'b01, 0));
        applyStimulus(0, 0, 2'b01, 0, mk(1, 2, 1, 0, 0, 2'b01, 0));
        applyStimulus(0, 1, 2'b00, 1, mk(0, 1, 0, 1, 0, 2'b01, 0));

        // Reset with group 1 pending abandons everything; later done is spurious.
        applyStimulus(0, 1, 2'b10, 0, mk(0, 1, 2, 0, 0, 2'b01, 0));
        applyStimulus(1, 1, 2'b00, 0, mkRst());
        chk("perf_rst_mid", 32'(perfCycles), 32'd0);
        applyStimulus(0, 1, 2'b00, 1, mk(0, 0, 0, 0, 0, 2'b10, 0));

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
